// File: rtl/es_nios2_mulx_seq.sv
// Multiply sequencer in front of the Nios II 32x32->low-32 multiply cell.
// MUL is one pass. MULX* builds the high word from four 16x16 passes plus a sign fix.
module es_nios2_mulx_seq #(
    parameter int unsigned CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_result,
    output logic        resp_valid,
    output logic [31:0] resp_result
);

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned HW = 16;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_UU  = 2'b01;
    localparam logic [1:0] OP_SS  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIX,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [1:0]              op_q;
    logic [W-1:0]            a_q, b_q;
    logic [1:0]              iss_cnt, iss_nxt;
    logic [1:0]              cap_cnt;
    logic [AW-1:0]           acc, acc_nxt;
    logic [CELL_LATENCY-1:0] cap_pipe;

    logic          accept;
    logic          capture;
    logic          is_mulx;
    logic [1:0]    op_sel;
    logic [W-1:0]  a_sel, b_sel;
    logic [W-1:0]  src1_nxt, src2_nxt;
    logic [AW-1:0] pp;
    logic [W-1:0]  corr_a, corr_b, hi_fix;

    // Next-state, next cell operands and accumulator/fix datapath
    always_comb begin
        state_nxt = state;
        iss_nxt   = iss_cnt;
        accept    = 1'b0;
        op_sel    = op_q;
        a_sel     = a_q;
        b_sel     = b_q;
        src1_nxt  = '0;
        src2_nxt  = '0;
        capture   = cap_pipe[CELL_LATENCY-1];
        is_mulx   = (op_q != OP_MUL);

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                    iss_nxt   = 2'd0;
                    op_sel    = req_op;
                    a_sel     = req_src1;
                    b_sel     = req_src2;
                end
            end
            S_ISSUE: begin
                if (!is_mulx || iss_cnt == 2'd3) state_nxt = S_DRAIN;
                else                             iss_nxt   = iss_cnt + 2'd1;
            end
            S_DRAIN: begin
                if (capture && (!is_mulx || cap_cnt == 2'd3))
                    state_nxt = is_mulx ? S_FIX : S_DONE;
            end
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Operands are registered, so they are chosen for the state being entered
        if (state_nxt == S_ISSUE) begin
            if (op_sel == OP_MUL) begin
                src1_nxt = a_sel;
                src2_nxt = b_sel;
            end else begin
                src1_nxt = {HW'(0), iss_nxt[1] ? a_sel[31:16] : a_sel[15:0]};
                src2_nxt = {HW'(0), iss_nxt[0] ? b_sel[31:16] : b_sel[15:0]};
            end
        end

        case (cap_cnt)
            2'd0:    pp = {W'(0), mul_result};
            2'd3:    pp = {mul_result, W'(0)};
            default: pp = {HW'(0), mul_result, HW'(0)};
        endcase
        acc_nxt = acc + pp;

        corr_a = (op_q != OP_UU && a_q[31]) ? b_q : W'(0);
        corr_b = (op_q == OP_SS && b_q[31]) ? a_q : W'(0);
        hi_fix = acc[AW-1:W] - corr_a - corr_b;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            iss_cnt     <= '0;
            cap_cnt     <= '0;
            acc         <= '0;
            cap_pipe    <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            mul_src1    <= '0;
            mul_src2    <= '0;
        end else begin
            state     <= state_nxt;
            iss_cnt   <= iss_nxt;
            req_ready <= (state_nxt == S_IDLE);
            resp_valid <= (state_nxt == S_DONE);
            mul_src1  <= src1_nxt;
            mul_src2  <= src2_nxt;

            // One bit per issued pass, aligned to when its product appears
            cap_pipe[0] <= (state == S_ISSUE);
            for (int i = 1; i < int'(CELL_LATENCY); i++) begin
                cap_pipe[i] <= cap_pipe[i-1];
            end

            if (accept) begin
                op_q    <= req_op;
                a_q     <= req_src1;
                b_q     <= req_src2;
                acc     <= '0;
                cap_cnt <= '0;
            end else if (capture) begin
                if (is_mulx) begin
                    acc     <= acc_nxt;
                    cap_cnt <= cap_cnt + 2'd1;
                end else begin
                    resp_result <= mul_result;
                end
            end

            if (state == S_FIX) resp_result <= hi_fix;
        end
    end

endmodule
